// File: rtl/if_stage_pkg.sv
// Shared CPU definitions used by the fetch stage: next-PC select encodings,
// reset/exception vectors and the supervisor-preserving PC increment.
// Imported by if_stage and if_id_reg.
package if_stage_pkg;

   // Next-PC select codes driven by decode; 1, 6 and 7 fall back to sequential.
   typedef enum logic [2:0] {
      PCSRC_SEQ   = 3'd0,
      PCSRC_JUMP  = 3'd2,
      PCSRC_JR    = 3'd3,
      PCSRC_ILLOP = 3'd4,
      PCSRC_XADR  = 3'd5
   } pcsrc_e;

   localparam logic [31:0] RESET_VEC = 32'h8000_0000;
   localparam logic [31:0] ILLOP_VEC = 32'h8000_0004;
   localparam logic [31:0] XADR_VEC  = 32'h8000_0008;

   // Bit 31 is the supervisor bit; only the low 31 bits advance (mod 2^31).
   function automatic logic [31:0] pc_inc4(input logic [31:0] pc);
      logic [30:0] low;
      low = pc[30:0] + 31'd4;
      return {pc[31], low};
   endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction memory fetch bus: address out, combinational instruction word back.
// Ports: IM_Addr (32, fetcher -> memory), IM_Data (32, memory -> fetcher).
// master = fetch stage, slave = instruction memory.
interface if_stage_if;
   logic [31:0] IM_Addr;
   logic [31:0] IM_Data;

   modport master (output IM_Addr, input IM_Data);
   modport slave  (input IM_Addr, output IM_Data);
endinterface

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: captures instruction, PC+4 and valid; 1-cycle latency.
// No handshake: write holds when low, flush clears to a bubble and wins over write.
// Ports: clk, reset (sync, active-high), write, flush, instr_in, pc_plus_4_in -> instr, pc_plus_4, valid.
module if_id_reg
   import if_stage_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        write,
   input  logic        flush,
   input  logic [31:0] instr_in,
   input  logic [31:0] pc_plus_4_in,
   output logic [31:0] instr,
   output logic [31:0] pc_plus_4,
   output logic        valid
);

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         // A flushed slot becomes an all-zero bubble regardless of write.
         instr     <= '0;
         pc_plus_4 <= '0;
         valid     <= 1'b0;
      end else if (write) begin
         instr     <= instr_in;
         pc_plus_4 <= pc_plus_4_in;
         valid     <= 1'b1;
      end
   end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, next-PC select and IF/ID register; fetch->ID latency 1.
// Stalls via PCWrite/IF_ID_write (hold), bubbles via IF_ID_flush; a taken EX branch always redirects.
// Ports: clk, reset, hazard controls, ID/EX redirect inputs, im (fetch bus master), PC, IF/ID outputs,
// StallCnt/FlushCnt. Optional macro IF_STAGE_PERF_CNT_EN enables the counters (else they read 0).
module if_stage
   import if_stage_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic         PCWrite,
   input  logic         IF_ID_write,
   input  logic         IF_ID_flush,
   input  logic [2:0]   ID_PCSrc,
   input  logic [31:0]  ID_JumpTarget,
   input  logic [31:0]  ID_JrTarget,
   input  logic         EX_BranchTaken,
   input  logic [31:0]  EX_BranchTarget,
   if_stage_if.master   im,
   output logic [31:0]  PC,
   output logic [31:0]  IF_ID_Instr,
   output logic [31:0]  IF_ID_PC_plus_4,
   output logic         IF_ID_valid,
   output logic [31:0]  StallCnt,
   output logic [31:0]  FlushCnt
);

   logic [31:0] pc_q;
   logic [31:0] pc_plus_4;
   logic [31:0] next_pc;
   logic        pc_load;

   assign pc_plus_4 = pc_inc4(pc_q);

   // EX branch is older than the ID redirect, so it takes priority.
   always_comb begin
      next_pc = pc_plus_4;
      if (EX_BranchTaken) begin
         next_pc = EX_BranchTarget;
      end else begin
         case (ID_PCSrc)
            PCSRC_JUMP:  next_pc = ID_JumpTarget;
            PCSRC_JR:    next_pc = ID_JrTarget;
            PCSRC_ILLOP: next_pc = ILLOP_VEC;
            PCSRC_XADR:  next_pc = XADR_VEC;
            default:     next_pc = pc_plus_4;
         endcase
      end
   end

   // A taken branch must redirect even while the hazard unit stalls the PC.
   assign pc_load = PCWrite || EX_BranchTaken;

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q <= RESET_VEC;
      end else if (pc_load) begin
         pc_q <= next_pc;
      end
   end

   assign PC         = pc_q;
   assign im.IM_Addr = pc_q;

   if_id_reg u_if_id_reg (
      .clk          (clk),
      .reset        (reset),
      .write        (IF_ID_write),
      .flush        (IF_ID_flush),
      .instr_in     (im.IM_Data),
      .pc_plus_4_in (pc_plus_4),
      .instr        (IF_ID_Instr),
      .pc_plus_4    (IF_ID_PC_plus_4),
      .valid        (IF_ID_valid)
   );

`ifdef IF_STAGE_PERF_CNT_EN
   logic [31:0] stall_cnt_q;
   logic [31:0] flush_cnt_q;

   // Both counters saturate rather than wrap so long runs stay meaningful.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (!pc_load && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
         end
         if (IF_ID_flush && (flush_cnt_q != 32'hFFFF_FFFF)) begin
            flush_cnt_q <= flush_cnt_q + 32'd1;
         end
      end
   end

   assign StallCnt = stall_cnt_q;
   assign FlushCnt = flush_cnt_q;
`else
   assign StallCnt = '0;
   assign FlushCnt = '0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage.
// Instruction memory model returns IM_Addr ^ 32'h0F0F0F0F.
// Counter expectations follow the IF_STAGE_PERF_CNT_EN build option.
module tb_if_stage;

   localparam logic [31:0] MASK = 32'h0F0F_0F0F;

`ifdef IF_STAGE_PERF_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        PCWrite;
   logic        IF_ID_write;
   logic        IF_ID_flush;
   logic [2:0]  ID_PCSrc;
   logic [31:0] ID_JumpTarget;
   logic [31:0] ID_JrTarget;
   logic        EX_BranchTaken;
   logic [31:0] EX_BranchTarget;
   logic [31:0] PC;
   logic [31:0] IF_ID_Instr;
   logic [31:0] IF_ID_PC_plus_4;
   logic        IF_ID_valid;
   logic [31:0] StallCnt;
   logic [31:0] FlushCnt;

   int checks   = 0;
   int failures = 0;

   if_stage_if imb ();

   assign imb.IM_Data = imb.IM_Addr ^ MASK;

   if_stage dut (
      .clk             (clk),
      .reset           (reset),
      .PCWrite         (PCWrite),
      .IF_ID_write     (IF_ID_write),
      .IF_ID_flush     (IF_ID_flush),
      .ID_PCSrc        (ID_PCSrc),
      .ID_JumpTarget   (ID_JumpTarget),
      .ID_JrTarget     (ID_JrTarget),
      .EX_BranchTaken  (EX_BranchTaken),
      .EX_BranchTarget (EX_BranchTarget),
      .im              (imb.master),
      .PC              (PC),
      .IF_ID_Instr     (IF_ID_Instr),
      .IF_ID_PC_plus_4 (IF_ID_PC_plus_4),
      .IF_ID_valid     (IF_ID_valid),
      .StallCnt        (StallCnt),
      .FlushCnt        (FlushCnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge, then settle 1ns before checking/driving.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_ifid(input string tag, input logic [31:0] ins, input logic [31:0] p4,
                             input logic vld);
      check({tag, "_instr"}, IF_ID_Instr, ins);
      check({tag, "_pc4"}, IF_ID_PC_plus_4, p4);
      check({tag, "_valid"}, {31'd0, IF_ID_valid}, {31'd0, vld});
   endtask

   initial begin
      #100000;
      $display("FAIL timeout simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      reset           = 1'b1;
      PCWrite         = 1'b1;
      IF_ID_write     = 1'b1;
      IF_ID_flush     = 1'b0;
      ID_PCSrc        = 3'd0;
      ID_JumpTarget   = 32'h0;
      ID_JrTarget     = 32'h0;
      EX_BranchTaken  = 1'b0;
      EX_BranchTarget = 32'h0;
      #2;

      // Reset state
      step();
      step();
      check("rst_pc", PC, 32'h8000_0000);
      check("rst_imaddr", imb.IM_Addr, 32'h8000_0000);
      check_ifid("rst", 32'h0, 32'h0, 1'b0);
      check("rst_stall", StallCnt, 32'h0);
      check("rst_flush", FlushCnt, 32'h0);

      // Free-running sequential fetch
      reset = 1'b0;
      step();
      check("seq1_pc", PC, 32'h8000_0004);
      check_ifid("seq1", 32'h8000_0000 ^ MASK, 32'h8000_0004, 1'b1);
      step();
      check("seq2_pc", PC, 32'h8000_0008);
      step();
      check("seq3_pc", PC, 32'h8000_000C);
      step();
      check("seq4_pc", PC, 32'h8000_0010);
      check_ifid("seq4", 32'h8000_000C ^ MASK, 32'h8000_0010, 1'b1);

      // Two-cycle stall: PC and IF/ID hold
      PCWrite     = 1'b0;
      IF_ID_write = 1'b0;
      step();
      check("stall1_pc", PC, 32'h8000_0010);
      check_ifid("stall1", 32'h8000_000C ^ MASK, 32'h8000_0010, 1'b1);
      step();
      check("stall2_pc", PC, 32'h8000_0010);
      check_ifid("stall2", 32'h8000_000C ^ MASK, 32'h8000_0010, 1'b1);
      check("stall2_cnt", StallCnt, CNT_EN ? 32'd2 : 32'd0);

      // Taken branch overrides PCWrite=0; flush bubbles IF/ID
      EX_BranchTaken  = 1'b1;
      EX_BranchTarget = 32'h8000_0100;
      IF_ID_flush     = 1'b1;
      step();
      check("br_pc", PC, 32'h8000_0100);
      check_ifid("br", 32'h0, 32'h0, 1'b0);
      check("br_flushcnt", FlushCnt, CNT_EN ? 32'd1 : 32'd0);
      check("br_stallcnt", StallCnt, CNT_EN ? 32'd2 : 32'd0);

      // jr then ILLOP then XADR then code 7 (sequential)
      EX_BranchTaken = 1'b0;
      IF_ID_flush    = 1'b0;
      PCWrite        = 1'b1;
      IF_ID_write    = 1'b1;
      ID_PCSrc       = 3'd3;
      ID_JrTarget    = 32'h0040_0020;
      step();
      check("jr_pc", PC, 32'h0040_0020);
      check_ifid("jr", 32'h8F0F_0E0F, 32'h8000_0104, 1'b1);
      ID_PCSrc = 3'd4;
      step();
      check("illop_pc", PC, 32'h8000_0004);
      ID_PCSrc = 3'd5;
      step();
      check("xadr_pc", PC, 32'h8000_0008);
      ID_PCSrc = 3'd7;
      step();
      check("src7_pc", PC, 32'h8000_000C);
      ID_PCSrc = 3'd1;
      step();
      check("src1_pc", PC, 32'h8000_0010);

      // Wrap with supervisor bit set: FFFFFFFC -> 80000000
      ID_PCSrc      = 3'd2;
      ID_JumpTarget = 32'hFFFF_FFFC;
      step();
      check("jmp_pc", PC, 32'hFFFF_FFFC);
      ID_PCSrc = 3'd0;
      step();
      check("wrap1_pc", PC, 32'h8000_0000);
      check_ifid("wrap1", 32'hF0F0_F0F3, 32'h8000_0000, 1'b1);

      // Wrap with supervisor bit clear: 7FFFFFFC -> 00000000
      ID_PCSrc      = 3'd2;
      ID_JumpTarget = 32'h7FFF_FFFC;
      step();
      ID_PCSrc = 3'd0;
      step();
      check("wrap0_pc", PC, 32'h0000_0000);

      // Branch has priority over a simultaneous jump
      ID_PCSrc        = 3'd2;
      ID_JumpTarget   = 32'h1234_5678;
      EX_BranchTaken  = 1'b1;
      EX_BranchTarget = 32'h0000_1000;
      step();
      check("brprio_pc", PC, 32'h0000_1000);
      EX_BranchTaken = 1'b0;

      // Flush with IF_ID_write=1 still clears
      ID_PCSrc    = 3'd0;
      IF_ID_flush = 1'b1;
      step();
      check("flushw_pc", PC, 32'h0000_1004);
      check_ifid("flushw", 32'h0, 32'h0, 1'b0);
      check("flushw_cnt", FlushCnt, CNT_EN ? 32'd2 : 32'd0);
      IF_ID_flush = 1'b0;

      // Reset alongside a jump: reset wins
      step();
      ID_PCSrc      = 3'd2;
      ID_JumpTarget = 32'h1234_5678;
      reset         = 1'b1;
      step();
      check("rstj_pc", PC, 32'h8000_0000);
      check_ifid("rstj", 32'h0, 32'h0, 1'b0);
      check("rstj_stall", StallCnt, 32'h0);
      check("rstj_flush", FlushCnt, 32'h0);

      // First fetch after reset comes from the reset vector
      reset    = 1'b0;
      ID_PCSrc = 3'd0;
      step();
      check("post_pc", PC, 32'h8000_0004);
      check_ifid("post", 32'h8F0F_0F0F, 32'h8000_0004, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
